// File: rtl/shamt_pkg.sv
// Shared constants and types for the shift-amount extraction stage.
package shamt_pkg;

  localparam int IW_DEF        = 32;
  localparam int SW_DEF        = 6;
  localparam int FIELD_LSB_DEF = 10;
  localparam int DW_DEF        = 64;

  typedef enum logic {
    SRC_IMM = 1'b0,
    SRC_VAR = 1'b1
  } shamt_src_e;

endpackage

// File: rtl/shamt_fifo.sv
// Generic DEPTH x SW FIFO with occupancy count, wrap-around pointers and flush.
// DEPTH need not be a power of two; pointers wrap explicitly at DEPTH-1.
module shamt_fifo #(
  parameter int DEPTH = 2,
  parameter int SW    = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push_valid,
  output logic          push_ready,
  input  logic [SW-1:0] push_data,
  output logic          pop_valid,
  input  logic          pop_ready,
  output logic [SW-1:0] pop_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] mem_q [DEPTH];
  logic [SW-1:0] mem_d [DEPTH];
  logic          push;
  logic          pop;

  // push_ready depends only on occupancy, never on pop_ready.
  assign push_ready = (count_q < FULL_CNT);
  assign pop_valid  = (count_q != '0);
  assign pop_data   = pop_valid ? mem_q[rd_ptr_q] : '0;

  assign push = push_valid && push_ready && !flush;
  assign pop  = pop_valid && pop_ready && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/shamt_pipe.sv
// Elastic shift-amount extraction stage: picks the shamt from an ibus field or
// rs_val and buffers it. Define SHAMT_SAT_EN to saturate oversized rs_val shamts.
module shamt_pipe
  import shamt_pkg::*;
#(
  parameter int IW        = IW_DEF,
  parameter int SW        = SW_DEF,
  parameter int FIELD_LSB = FIELD_LSB_DEF,
  parameter int DW        = DW_DEF,
  parameter int DEPTH     = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] ibus,
  input  logic [DW-1:0] rs_val,
  input  logic          var_sel,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [SW-1:0] shamt_out,
  output logic          shamt_zero
);

  // Handshake: a transfer happens on a rising edge where valid && ready && !flush;
  // valid never waits on ready, and flush cancels both sides for that edge.

  if (FIELD_LSB + SW > IW) begin : g_field_range_err
    $error("shamt_pipe: FIELD_LSB+SW exceeds IW");
  end
  if (DEPTH < 1) begin : g_depth_err
    $error("shamt_pipe: DEPTH must be at least 1");
  end

  shamt_src_e    src;
  logic [SW-1:0] imm_shamt;
  logic [SW-1:0] var_shamt;
  logic [SW-1:0] shamt_in;
  logic          unused_ibus;
  logic          unused_rs_hi;

  assign unused_ibus  = ^ibus;
  assign unused_rs_hi = |(rs_val >> SW);

  always_comb begin
    src       = shamt_src_e'(var_sel);
    imm_shamt = ibus[FIELD_LSB+SW-1:FIELD_LSB];
`ifdef SHAMT_SAT_EN
    var_shamt = (|(rs_val >> SW)) ? '1 : rs_val[SW-1:0];
`else
    var_shamt = rs_val[SW-1:0];
`endif
    shamt_in  = (src == SRC_VAR) ? var_shamt : imm_shamt;
  end

  shamt_fifo #(
    .DEPTH (DEPTH),
    .SW    (SW)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  (shamt_in),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (shamt_out)
  );

  assign shamt_zero = out_valid && (shamt_out == '0);

endmodule

// File: tb/tb_shamt_pipe.sv
// Self-checking bench for shamt_pipe: directed scenarios plus a random phase,
// scored against an expected-shamt queue and an occupancy model.
module tb_shamt_pipe;

  localparam int IW        = 32;
  localparam int SW        = 6;
  localparam int FIELD_LSB = 10;
  localparam int DW        = 64;
  localparam int DEPTH     = 2;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] ibus;
  logic [DW-1:0] rs_val;
  logic          var_sel;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] shamt_out;
  logic          shamt_zero;

  logic [SW-1:0] exp_q[$];
  int            model_cnt;
  int            n_compared;
  int            n_mismatched;

  shamt_pipe #(
    .IW        (IW),
    .SW        (SW),
    .FIELD_LSB (FIELD_LSB),
    .DW        (DW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ibus       (ibus),
    .rs_val     (rs_val),
    .var_sel    (var_sel),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .shamt_out  (shamt_out),
    .shamt_zero (shamt_zero)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [SW-1:0] ref_shamt(input logic [IW-1:0] ib, input logic [DW-1:0] rs,
                                              input logic vs);
    logic [SW-1:0] r;
    if (!vs) begin
      r = ib[FIELD_LSB +: SW];
    end else begin
      r = rs[SW-1:0];
`ifdef SHAMT_SAT_EN
      if ((rs >> SW) != '0) r = '1;
`endif
    end
    return r;
  endfunction

  // One clock: check outputs against the model, predict the edge, then advance.
  task automatic cycle();
    logic do_push;
    logic do_pop;
    check("in_ready", in_ready, (model_cnt < DEPTH));
    check("out_valid", out_valid, (model_cnt != 0));
    check("count", 64'(dut.u_fifo.count_q), 64'(model_cnt));
    if (model_cnt != 0 && exp_q.size() != 0) begin
      check("shamt_out", shamt_out, exp_q[0]);
      check("shamt_zero", shamt_zero, (exp_q[0] == '0));
    end else begin
      check("shamt_out_empty", shamt_out, '0);
      check("shamt_zero_empty", shamt_zero, 1'b0);
    end
    if (flush) begin
      exp_q.delete();
      model_cnt = 0;
    end else begin
      do_pop  = (model_cnt != 0) && out_ready;
      do_push = in_valid && (model_cnt < DEPTH);
      if (do_pop && exp_q.size() != 0) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(ref_shamt(ibus, rs_val, var_sel));
      model_cnt = model_cnt + int'(do_push) - int'(do_pop);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [IW-1:0] ib, input logic [DW-1:0] rs,
                       input logic vs, input logic rdy, input logic fl);
    in_valid  = v;
    ibus      = ib;
    rs_val    = rs;
    var_sel   = vs;
    out_ready = rdy;
    flush     = fl;
    cycle();
  endtask

  function automatic logic [IW-1:0] field(input int v);
    return IW'(v) << FIELD_LSB;
  endfunction

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    model_cnt    = 0;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    ibus         = '0;
    rs_val       = '0;
    var_sel      = 1'b0;
    flush        = 1'b0;
    out_ready    = 1'b0;
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state, then single immediate push (field 0x0B), then pop.
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h0000_2C00, '0, 1'b0, 1'b0, 1'b0);
    check("single_shamt", shamt_out, 6'h0B);
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    // Variable mode: 0x45 -> 5; 0x40 -> 0 (truncate) or 0x3F (saturate).
    drive(1'b1, '0, 64'h45, 1'b1, 1'b0, 1'b0);
    check("var_45", shamt_out, 6'h05);
    drive(1'b1, '0, 64'h40, 1'b1, 1'b1, 1'b0);
`ifdef SHAMT_SAT_EN
    check("var_40_sat", shamt_out, 6'h3F);
`else
    check("var_40_trunc", shamt_out, 6'h00);
    check("var_40_zero", shamt_zero, 1'b1);
`endif
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    // Fill to full, third offer with out_ready=1 must be refused.
    drive(1'b1, field(3), '0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, field(7), '0, 1'b0, 1'b0, 1'b0);
    check("full_in_ready", in_ready, 1'b0);
    drive(1'b1, field(9), '0, 1'b0, 1'b1, 1'b0);
    check("after_full_head", shamt_out, 6'd7);
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    // Streaming 0..9 with both sides always ready.
    for (int i = 0; i < 10; i++) drive(1'b1, field(i), '0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    // Flush with two entries buffered and a concurrent push.
    drive(1'b1, field(11), '0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, field(12), '0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1; ibus = field(13); out_ready = 1'b1; flush = 1'b1;
    check("flush_in_ready", in_ready, 1'b0);
    cycle();
    check("post_flush_valid", out_valid, 1'b0);
    drive(1'b1, field(21), '0, 1'b0, 1'b0, 1'b0);
    check("post_flush_head", shamt_out, 6'd21);
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset between edges with one entry buffered.
    drive(1'b1, field(33), '0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 1'b0);
    check("async_rst_shamt", shamt_out, '0);
    check("async_rst_zero", shamt_zero, 1'b0);
    check("async_rst_ready", in_ready, 1'b1);
    exp_q.delete();
    model_cnt = 0;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, field(44), '0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    // Random traffic including occasional flushes and wide rs_val.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom,
            ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : DW'($urandom_range(0, 127)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0));
    end
    for (int i = 0; i < DEPTH + 1; i++) drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/shamt_pipe.md
Name: shamt_pipe

Overview:
Parametrised, elastic shift-amount extraction stage between instruction decode and the shifter in the execute stage. Each accepted instruction produces one shift amount from one of two sources:
- Immediate mode: a configurable field of the instruction word.
- Variable mode: the low bits of a register operand.

Results are buffered in a small FIFO with valid/ready handshakes on both sides, and the stage supports pipeline flush.

Parameters:
- IW, 32, instruction word width.
- SW, 6, shift-amount width.
- FIELD_LSB, 10, LSB of the immediate shamt field in ibus; the field is ibus[FIELD_LSB+SW-1:FIELD_LSB].
- DW, 64, register operand width.
- DEPTH, 2, FIFO entries; minimum 1, not restricted to a power of two.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  upstream presents an instruction.
- in_ready  out  1  stage can accept; equals (count < DEPTH).
- ibus  in  IW  instruction word.
- rs_val  in  DW  register operand for variable shifts.
- var_sel  in  1  1 = take shamt from rs_val; 0 = take it from the ibus field.
- flush  in  1  discard all buffered and incoming entries.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  downstream consumes the head entry.
- shamt_out  out  SW  head shift amount; 0 when empty.
- shamt_zero  out  1  head shamt == 0, gated by out_valid.

Behaviour:
- Reset (asynchronous on rst_n low):
  - count, wr_ptr and rd_ptr clear to 0.
  - out_valid = 0, shamt_out = 0, shamt_zero = 0.
  - Storage contents are don't-care.
  - Reset mid-operation drops all entries immediately.
- Push: in_valid && in_ready && !flush. The extracted shamt is written at wr_ptr on the clock edge.
- Pop: out_valid && out_ready && !flush. rd_ptr advances.
- Extraction:
  - var_sel = 0: ibus[FIELD_LSB+SW-1:FIELD_LSB].
  - var_sel = 1: rs_val[SW-1:0] (truncation; see Optional Feature).
  - Computed combinationally at the input and stored in the entry; the output does not depend on live ibus/rs_val.
- Latency: 1 cycle. An entry pushed at edge N is visible with out_valid = 1 after edge N when the FIFO was empty. There is no combinational input-to-output bypass.
- Pointers:
  - Each increments and wraps from DEPTH-1 to 0.
  - count updates by +1 on push only, -1 on pop only, unchanged on both or neither.
- Full (count == DEPTH): in_ready = 0, even if out_ready = 1 in the same cycle. in_ready is not a function of out_ready.
- Empty (count == 0): out_valid = 0, shamt_out = 0, and an out_ready assertion is ignored.
- Simultaneous push and pop when 0 < count < DEPTH: both happen and count is unchanged.
- Simultaneous push and pop with DEPTH = 1: impossible, because in_ready = 0 while full.
- Flush has priority:
  - On the edge, count and both pointers return to 0.
  - A push or pop requested in the same cycle is dropped.
  - out_valid = 0 the following cycle.
  - in_ready is unaffected during the flush cycle.
- Out-of-range FIELD_LSB (FIELD_LSB+SW > IW) is a parameter error and must be caught by an elaboration-time check.

Optional Feature:
- Macro: SHAMT_SAT_EN.
- Defined: in variable mode, if any bit of rs_val[DW-1:SW] is 1, the stored shamt saturates to all ones (2^SW-1). Immediate mode is unaffected.
- Undefined: variable mode truncates to rs_val[SW-1:0].

Decomposition:
- Package shamt_pkg holds:
  - default constants: IW_DEF=32, SW_DEF=6, FIELD_LSB_DEF=10, DW_DEF=64;
  - a typedef for the shamt source select (SRC_IMM=0, SRC_VAR=1).
- Sub-module shamt_fifo: a generic DEPTH x SW FIFO with count/pointers, flush and the in_ready/out_valid logic.
- shamt_pipe itself holds the extraction mux and the saturation logic.

Test Plan:
- Reset then single push: ibus=32'h0000_2C00, var_sel=0 -> next cycle out_valid=1, shamt_out=6'h0B, shamt_zero=0; with out_ready=1 -> out_valid=0 after the pop edge.
- Variable mode: var_sel=1, rs_val=64'h45 -> shamt_out=6'h05. Then rs_val=64'h40:
  - SHAMT_SAT_EN defined -> 6'h3F;
  - undefined -> 6'h00 with shamt_zero=1.
- Fill with DEPTH=2 and out_ready=0: push 3 (ibus field), then 7 -> in_ready=0 after the second push. A third in_valid with out_ready=1 in the same cycle is not accepted. Then outputs 3 and 7 appear in order.
- Streaming: in_valid=out_ready=1 for 10 cycles with ibus fields 0..9 -> outputs 0..9 in order, count stable at 1, no drops.
- Flush: with 2 entries buffered, assert flush together with in_valid -> next cycle out_valid=0, count=0. The dropped input never appears at the output.
- Asynchronous reset mid-stream: pull rst_n low between clock edges while 1 entry is buffered -> out_valid and shamt_out go to 0 without waiting for a clock edge; after release, behaviour is normal.
